// File: rtl/acc_drain_ctrl.sv
// acc_drain_ctrl: sequences the systolic-array column accumulator.
// Accepts a job of num_passes partial-sum vectors, accumulates each lane
// (unsigned, modulo 2^VERTICAL_BW), then drains the ARR_SIZE lane totals one
// per cycle to the output buffer over a valid/ready handshake.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   start           - job request (IDLE only), with num_passes / base_addr
//   psum_valid/data - bottom-row partial-sum vector, lane k at [k*VERTICAL_BW +: VERTICAL_BW]
//   busy, done      - job in progress / one-cycle completion pulse
//   out_valid/ready - drain handshake; out_data = lane total, out_addr = buffer address
module acc_drain_ctrl #(
    parameter int unsigned ARR_SIZE    = 4,
    parameter int unsigned VERTICAL_BW = 32,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned PASS_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [PASS_W-1:0]               num_passes,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic                            psum_valid,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] psum_data,
    output logic                            busy,
    output logic                            done,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [VERTICAL_BW-1:0]          out_data,
    output logic [ADDR_W-1:0]               out_addr
);

    localparam int unsigned LANE_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic [PASS_W-1:0]        r_num;
    logic [PASS_W-1:0]        r_pass_cnt;
    logic [LANE_W-1:0]        r_lane;
    logic [VERTICAL_BW-1:0]   r_acc [ARR_SIZE];
    logic                     r_busy;
    logic                     r_done;
    logic                     r_out_valid;
    logic [VERTICAL_BW-1:0]   r_out_data;
    logic [ADDR_W-1:0]        r_out_addr;

    logic                     w_last_pass;
    logic                     w_last_lane;

    assign w_last_pass = (r_pass_cnt + PASS_W'(1)) == r_num;
    assign w_last_lane = r_lane == LANE_W'(ARR_SIZE - 1);

    // Controller state, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_pass_cnt  <= '0;
            r_lane      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            for (int k = 0; k < int'(ARR_SIZE); k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && (num_passes != '0)) begin
                        r_num      <= num_passes;
                        r_out_addr <= base_addr;
                        r_pass_cnt <= '0;
                        r_lane     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCUM;
                        for (int k = 0; k < int'(ARR_SIZE); k++) begin
                            r_acc[k] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (psum_valid) begin
                        for (int k = 0; k < int'(ARR_SIZE); k++) begin
                            r_acc[k] <= r_acc[k] + psum_data[k*VERTICAL_BW +: VERTICAL_BW];
                        end
                        r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                        if (w_last_pass) begin
                            // First drain word must already include this last psum.
                            r_out_data  <= r_acc[0] + psum_data[0 +: VERTICAL_BW];
                            r_out_valid <= 1'b1;
                            r_lane      <= '0;
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Data/addr only move on a handshake, so they hold under backpressure.
                    if (out_ready) begin
                        if (w_last_lane) begin
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_lane     <= r_lane + LANE_W'(1);
                            r_out_data <= r_acc[r_lane + LANE_W'(1)];
                            r_out_addr <= r_out_addr + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed bench for acc_drain_ctrl with hand-computed expectations.
module tb_acc_drain_ctrl;

    localparam int unsigned ARR_SIZE    = 4;
    localparam int unsigned VERTICAL_BW = 32;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned PASS_W      = 8;

    logic                            clk;
    logic                            rst;
    logic                            start;
    logic [PASS_W-1:0]               num_passes;
    logic [ADDR_W-1:0]               base_addr;
    logic                            psum_valid;
    logic [ARR_SIZE*VERTICAL_BW-1:0] psum_data;
    logic                            busy;
    logic                            done;
    logic                            out_valid;
    logic                            out_ready;
    logic [VERTICAL_BW-1:0]          out_data;
    logic [ADDR_W-1:0]               out_addr;

    int n_tests = 0;
    int n_fail  = 0;

    acc_drain_ctrl #(
        .ARR_SIZE   (ARR_SIZE),
        .VERTICAL_BW(VERTICAL_BW),
        .ADDR_W     (ADDR_W),
        .PASS_W     (PASS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_passes (num_passes),
        .base_addr  (base_addr),
        .psum_valid (psum_valid),
        .psum_data  (psum_data),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [PASS_W-1:0] np, input logic [ADDR_W-1:0] base);
        start      = 1'b1;
        num_passes = np;
        base_addr  = base;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic send_psum(input logic [31:0] l0, l1, l2, l3);
        psum_valid = 1'b1;
        psum_data  = {l3, l2, l1, l0};
        step();
        psum_valid = 1'b0;
    endtask

    // Drain the four lanes using ready pattern pat (bit i = cycle i, then 1).
    task automatic do_drain(input logic [31:0] e0, e1, e2, e3,
                            input logic [ADDR_W-1:0] base,
                            input logic [15:0] pat, input int npat);
        logic [31:0] exp_d [4];
        int lane;
        int cyc;
        exp_d = '{e0, e1, e2, e3};
        lane  = 0;
        cyc   = 0;
        while (lane < 4 && cyc < 40) begin
            out_ready = (cyc < npat) ? pat[cyc] : 1'b1;
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_data", out_data, exp_d[lane]);
            chk("drain_addr", 32'(out_addr), 32'(ADDR_W'(base + ADDR_W'(lane))));
            if (out_valid && out_ready) lane++;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_handshakes", 32'(lane), 32'd4);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        step();
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        num_passes = '0;
        base_addr  = '0;
        psum_valid = 1'b0;
        psum_data  = '0;
        out_ready  = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        rst = 1'b1;
        step();

        // Single pass
        start_job(8'd1, 4'd0);
        send_psum(32'd1, 32'd2, 32'd3, 32'd4);
        do_drain(32'd1, 32'd2, 32'd3, 32'd4, 4'd0, 16'h0000, 0);

        // Multi-pass with lane-0 overflow and gaps
        start_job(8'd3, 4'd0);
        send_psum(32'hFFFF_FFFF, 32'd10, 32'd10, 32'd10);
        step();
        step();
        chk("accum_no_valid", 32'(out_valid), 32'd0);
        send_psum(32'd1, 32'd10, 32'd10, 32'd10);
        step();
        chk("accum_still", 32'(out_valid), 32'd0);
        send_psum(32'd5, 32'd10, 32'd10, 32'd10);
        do_drain(32'd5, 32'd30, 32'd30, 32'd30, 4'd0, 16'h0000, 0);

        // Backpressure with address wrap: ready 1,0,0,1,1,0,1
        start_job(8'd1, 4'd14);
        send_psum(32'd7, 32'd8, 32'd9, 32'd10);
        do_drain(32'd7, 32'd8, 32'd9, 32'd10, 4'd14, 16'b1011001, 7);

        // start with zero passes is ignored
        start      = 1'b1;
        num_passes = 8'd0;
        base_addr  = 4'd5;
        step();
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_done", 32'(done), 32'd0);
        start = 1'b0;
        step();
        chk("zero_busy2", 32'(busy), 32'd0);
        chk("zero_done2", 32'(done), 32'd0);

        // start during ACCUM/DRAIN/DONE and psum during DRAIN are ignored
        start_job(8'd2, 4'd4);
        start      = 1'b1;
        num_passes = 8'd9;
        base_addr  = 4'd9;
        send_psum(32'd1, 32'd1, 32'd1, 32'd1);
        send_psum(32'd2, 32'd2, 32'd2, 32'd2);
        psum_valid = 1'b1;
        psum_data  = {4{32'h1000_0000}};
        do_drain(32'd3, 32'd3, 32'd3, 32'd3, 4'd4, 16'h0000, 0);
        start      = 1'b0;
        psum_valid = 1'b0;
        step();
        chk("ign_idle_busy", 32'(busy), 32'd0);

        // Reset mid-drain after the lane1 handshake
        start_job(8'd1, 4'd0);
        send_psum(32'd5, 32'd6, 32'd7, 32'd8);
        out_ready = 1'b1;
        chk("mid_lane0", out_data, 32'd5);
        step();
        chk("mid_lane1", out_data, 32'd6);
        step();
        chk("mid_lane2", out_data, 32'd7);
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_valid2", 32'(out_valid), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_done", 32'(done), 32'd0);
        start_job(8'd1, 4'd2);
        send_psum(32'd1, 32'd1, 32'd1, 32'd1);
        do_drain(32'd1, 32'd1, 32'd1, 32'd1, 4'd2, 16'h0000, 0);

        // Back-to-back jobs: second start in the first IDLE cycle
        start_job(8'd1, 4'd0);
        send_psum(32'd100, 32'd200, 32'd300, 32'd400);
        do_drain(32'd100, 32'd200, 32'd300, 32'd400, 4'd0, 16'h0000, 0);
        start_job(8'd1, 4'd3);
        send_psum(32'd1, 32'd2, 32'd3, 32'd4);
        do_drain(32'd1, 32'd2, 32'd3, 32'd4, 4'd3, 16'h0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
